// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV core front end: instruction width and fetch stepping.
package rv_core_pkg;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;
    localparam int PC_ALIGN   = 2;
endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush and a per-entry mark bit that can be set on every stored entry at once.
module rv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       push_mark,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       mark_all,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_mark,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] marks;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];
    assign head_mark = marks[rd_ptr];

    // Mark-all is applied before a same-cycle push so the new entry keeps its own mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            marks  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            marks  <= '0;
        end else begin
            if (mark_all) begin
                marks <= '1;
            end
            if (do_push) begin
                mem[wr_ptr]   <= push_data;
                marks[wr_ptr] <= push_mark;
                wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues word fetches to a variable-latency IM, buffers {pc,inst}
// pairs for decode, and squashes all in-flight and queued fetches on redirect.
module if_prefetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       im_req_valid,
    input  logic                       im_req_ready,
    output logic [XLEN-1:0]            im_req_addr,
    input  logic                       im_rsp_valid,
    input  logic [ILEN-1:0]            im_rsp_data,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [XLEN-1:0]            d_pc,
    output logic [ILEN-1:0]            d_inst,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W = OCC_W + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << PC_ALIGN) - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    logic [XLEN-1:0]  f_pc;
    logic [XLEN-1:0]  tag_pc;
    logic             tag_kill;
    logic             tag_full;
    logic             tag_empty;
    logic [INF_W-1:0] inflight;
    fetch_entry_t     ins_in;
    fetch_entry_t     ins_head;
    logic             ins_full;
    logic             ins_empty;
    logic             ins_head_mark;
    logic [SUM_W-1:0] committed;
    logic             req_fire;
    logic             rsp_take;
    logic             ins_push;
    logic             ins_pop;

    // Every outstanding request already owns a queue slot, so responses never need backpressure.
    assign committed    = SUM_W'(inflight) + SUM_W'(occupancy);
    assign im_req_valid = !rst && !redirect && !tag_full && (committed < SUM_W'(DEPTH));
    assign im_req_addr  = f_pc;
    assign req_fire     = im_req_valid && im_req_ready;

    assign rsp_take = im_rsp_valid && !rst && !tag_empty;
    assign ins_push = rsp_take && !tag_kill && !redirect;
    assign ins_in   = '{pc: tag_pc, inst: im_rsp_data};

    assign d_valid = !ins_empty && !redirect;
    assign ins_pop = d_valid && d_ready;
    assign d_pc    = ins_head.pc;
    assign d_inst  = ins_head.inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc <= RESET_PC;
        end else if (redirect) begin
            f_pc <= redirect_pc & ALIGN_MASK;
        end else if (req_fire) begin
            f_pc <= f_pc + XLEN'(INST_BYTES);
        end
    end

    // Tag queue: the mark bit is the kill flag, set on every in-flight fetch by a redirect.
    rv_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (f_pc),
        .push_mark (1'b0),
        .pop       (rsp_take),
        .flush     (1'b0),
        .mark_all  (redirect),
        .head_data (tag_pc),
        .head_mark (tag_kill),
        .count     (inflight),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    rv_sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_ins_q (
        .clk       (clk),
        .rst       (rst),
        .push      (ins_push),
        .push_data (ins_in),
        .push_mark (1'b0),
        .pop       (ins_pop),
        .flush     (redirect),
        .mark_all  (1'b0),
        .head_data (ins_head),
        .head_mark (ins_head_mark),
        .count     (occupancy),
        .full      (ins_full),
        .empty     (ins_empty)
    );

    assert property (@(posedge clk) disable iff (rst) !(im_rsp_valid && inflight == '0));
    assert property (@(posedge clk) disable iff (rst) occupancy <= OCC_W'(DEPTH));
    assert property (@(posedge clk) (RESET_PC & ~ALIGN_MASK) == '0);
    assert property (@(posedge clk) disable iff (rst) !(ins_push && ins_full && !ins_pop));
    assert property (@(posedge clk) disable iff (rst) !(!ins_empty && ins_head_mark));
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: a PC-stream model predicts every decode entry,
// a monitor compares each decode handshake against it.
module tb_if_prefetch_unit;
    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    typedef struct {
        logic [63:0] addr;
        longint      due;
    } pend_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              im_req_valid;
    logic              im_req_ready = 1'b0;
    logic [XLEN-1:0]   im_req_addr;
    logic              im_rsp_valid = 1'b0;
    logic [ILEN-1:0]   im_rsp_data = '0;
    logic              redirect = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              d_valid;
    logic              d_ready = 1'b0;
    logic [XLEN-1:0]   d_pc;
    logic [ILEN-1:0]   d_inst;
    logic [OCC_W-1:0]  occupancy;

    pend_t       rsp_q[$];
    exp_t        exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] model_pc;
    longint      cyc = 0;
    longint      last_due = 0;
    int          total = 0;
    int          bad = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          dready_pct = 100;
    int          req_count = 0;
    int          pop_count = 0;

    if_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC ('0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .im_req_valid (im_req_valid),
        .im_req_ready (im_req_ready),
        .im_req_addr  (im_req_addr),
        .im_rsp_valid (im_rsp_valid),
        .im_rsp_data  (im_rsp_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_pc         (d_pc),
        .d_inst       (d_inst),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h5EED_0013;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Two reset cycles; a stray response is driven in the first one and must be ignored.
    task automatic reset_dut();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        redirect = 1'b0;
        d_ready = 1'b0;
        im_req_ready = 1'b0;
        im_rsp_valid = 1'b1;
        im_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        cyc++;
        im_rsp_valid = 1'b0;
        #1;
        check_output("rst_req_valid", 64'(im_req_valid), 64'd0);
        check_output("rst_d_valid", 64'(d_valid), 64'd0);
        check_output("rst_occupancy", 64'(occupancy), 64'd0);
        check_output("rst_d_pc", d_pc, 64'd0);
        check_output("rst_d_inst", 64'(d_inst), 64'd0);
        check_output("rst_req_addr", im_req_addr, 64'd0);
        rsp_q.delete();
        exp_q.delete();
        req_log.delete();
        model_pc = 64'd0;
        last_due = cyc;
        req_count = 0;
        pop_count = 0;
    endtask

    // One clock of stimulus: IM response/ready, decode ready, optional redirect; then model update.
    task automatic apply_stimulus(input logic do_redir, input logic [63:0] rpc);
        pend_t  p;
        longint due;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            p = rsp_q.pop_front();
            im_rsp_valid = 1'b1;
            im_rsp_data = inst_of(p.addr);
        end else begin
            im_rsp_valid = 1'b0;
            im_rsp_data = $urandom;
        end
        im_req_ready = ($urandom_range(99) < ready_pct);
        d_ready = ($urandom_range(99) < dready_pct);
        redirect = do_redir;
        redirect_pc = do_redir ? rpc : {$urandom, $urandom};
        #1;
        if (d_valid && d_ready) begin
            pop_count++;
        end
        if (redirect) begin
            exp_q.delete();
            model_pc = rpc & ~64'd3;
        end else if (im_req_valid && im_req_ready) begin
            check_output("req_addr", im_req_addr, model_pc);
            due = cyc + longint'($urandom_range(lat_max, lat_min));
            if (due <= last_due) begin
                due = last_due + 1;
            end
            last_due = due;
            p.addr = im_req_addr;
            p.due = due;
            rsp_q.push_back(p);
            exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc)});
            req_log.push_back(im_req_addr);
            model_pc = model_pc + 64'd4;
            req_count++;
        end
    endtask

    // Monitor: every decode handshake must match the oldest predicted entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && d_valid && d_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL d_unexpected actual_pc=0x%0h required=no_entry", d_pc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("d_pc", d_pc, e.pc);
                    check_output("d_inst", 64'(d_inst), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        int          first_valid;
        int          start_req;
        logic [63:0] rpc;

        // Streaming with single-cycle IM: one instruction per cycle, first one at cycle 2.
        reset_dut();
        lat_min = 1; lat_max = 1; ready_pct = 100; dready_pct = 100;
        first_valid = -1;
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(1'b0, 64'd0);
            if (d_valid && first_valid < 0) first_valid = k;
        end
        check_output("t1_first_d_valid_cycle", 64'(first_valid), 64'd2);
        check_output("t1_throughput", 64'(pop_count), 64'd10);

        // Decode stalled: queue fills, exactly DEPTH requests, then ordered drain.
        reset_dut();
        dready_pct = 0;
        for (int k = 0; k < 20; k++) apply_stimulus(1'b0, 64'd0);
        check_output("t2_req_count", 64'(req_count), 64'(DEPTH));
        check_output("t2_occupancy", 64'(occupancy), 64'(DEPTH));
        check_output("t2_req_valid_blocked", 64'(im_req_valid), 64'd0);
        dready_pct = 100;
        for (int k = 0; k < 12; k++) apply_stimulus(1'b0, 64'd0);
        check_output("t2_resume_addr", (req_log.size() > 4) ? req_log[4] : 64'hBAD, 64'd16);

        // Long latency with two fetches outstanding, then a misaligned redirect.
        reset_dut();
        lat_min = 3; lat_max = 3;
        apply_stimulus(1'b1, 64'h40);
        apply_stimulus(1'b0, 64'd0);
        apply_stimulus(1'b0, 64'd0);
        check_output("t3_outstanding", 64'(req_count), 64'd2);
        apply_stimulus(1'b1, 64'h1002);
        start_req = req_count;
        for (int k = 0; k < 20 && req_count == start_req; k++) apply_stimulus(1'b0, 64'd0);
        check_output("t3_redirect_addr", (req_count > start_req) ? req_log[req_log.size()-1] : 64'hBAD, 64'h1000);
        for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 64'd0);

        // Redirect colliding with a response and a decode handshake, then back-to-back redirects.
        reset_dut();
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 64'd0);
        apply_stimulus(1'b1, 64'h500);
        apply_stimulus(1'b1, 64'h200);
        check_output("t4_occ_after_redirect", 64'(occupancy), 64'd0);
        apply_stimulus(1'b1, 64'h300);
        check_output("t4_occ_after_b2b", 64'(occupancy), 64'd0);
        req_log.delete();
        for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 64'd0);
        check_output("t4_b2b_addr", (req_log.size() > 0) ? req_log[0] : 64'hBAD, 64'h300);

        // Address wrap at the top of the 64-bit space.
        req_log.delete();
        apply_stimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int k = 0; k < 20 && req_log.size() < 2; k++) apply_stimulus(1'b0, 64'd0);
        check_output("t5_top_addr", (req_log.size() > 0) ? req_log[0] : 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFC);
        check_output("t5_wrap_addr", (req_log.size() > 1) ? req_log[1] : 64'hBAD, 64'd0);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 64'd0);

        // Random traffic: latency, handshakes, redirects and occasional resets.
        lat_min = 1; lat_max = 5; ready_pct = 70; dready_pct = 60;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(999) < 2) begin
                reset_dut();
            end else if ($urandom_range(99) < 3) begin
                rpc = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)} : {32'h0, 32'($urandom)};
                apply_stimulus(1'b1, rpc);
            end else begin
                apply_stimulus(1'b0, 64'd0);
            end
        end

        // Stop fetching and drain: nothing predicted may be lost.
        ready_pct = 0; dready_pct = 100;
        for (int k = 0; k < 60 && (exp_q.size() != 0 || occupancy != 0); k++) apply_stimulus(1'b0, 64'd0);
        check_output("drain_expected_left", 64'(exp_q.size()), 64'd0);
        check_output("drain_occupancy", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
